neopixel_decoder: RTL and testbench

Receive-side model of the NeoPixel (WS2812-style) serial line driven on `neo_data` by the team's LED controller. It measures high-pulse widths to recover bits, assembles 24-bit GRB pixel words into a shadow buffer, and commits them to an active buffer when the line stays low for the latch interval. Its registered read port lets the verification bench, or an on-board display mirror, check what the chain would show.

---
 rtl/neopixel_decoder_if.sv | 33 +++
 rtl/neopixel_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_neopixel_decoder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/neopixel_decoder_if.sv
// Bundles the NeoPixel serial input and the active-buffer read port so the
// decoder and its environment share one typed connection.
interface neopixel_decoder_if;
    logic       neo_data;
    logic [2:0] rd_pixel_index;
    logic [1:0] rd_color_index;
    logic [7:0] rd_color_level;
    logic       frame_valid;
    logic       frame_error;
    logic [3:0] pixel_count;

    // Environment side: drives the line and the read indices.
    modport master (
        output neo_data,
        output rd_pixel_index,
        output rd_color_index,
        input  rd_color_level,
        input  frame_valid,
        input  frame_error,
        input  pixel_count
    );

    // Decoder side.
    modport slave (
        input  neo_data,
        input  rd_pixel_index,
        input  rd_color_index,
        output rd_color_level,
        output frame_valid,
        output frame_error,
        output pixel_count
    );
endinterface

// File: rtl/neopixel_decoder.sv
// Receive-side NeoPixel (WS2812-style) line decoder. High-pulse widths are
// measured to recover bits, 24-bit GRB words are collected in a shadow buffer,
// and a long low period (latch) commits the written shadow slots to the
// active buffer, which is readable through a registered byte port.
module neopixel_decoder #(
    parameter int NUM_PIXELS   = 5,
    parameter int MIN_HIGH     = 5,
    parameter int BIT_THRESH   = 27,
    parameter int MAX_HIGH     = 60,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic              clock,
    input  logic              reset,
    neopixel_decoder_if.slave bus
);

    localparam int HC_W = $clog2(MAX_HIGH + 1);
    localparam int LC_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [HC_W-1:0] HC_ONE      = HC_W'(1);
    localparam logic [HC_W-1:0] MIN_HIGH_C  = HC_W'(MIN_HIGH);
    localparam logic [HC_W-1:0] THRESH_C    = HC_W'(BIT_THRESH);
    localparam logic [HC_W-1:0] MAX_HIGH_C  = HC_W'(MAX_HIGH);
    localparam logic [HC_W-1:0] MAX_PRE_C   = HC_W'(MAX_HIGH - 1);
    localparam logic [LC_W-1:0] LC_ONE      = LC_W'(1);
    localparam logic [LC_W-1:0] LATCH_C     = LC_W'(LATCH_CYCLES);
    localparam logic [LC_W-1:0] LATCH_PRE_C = LC_W'(LATCH_CYCLES - 1);
    localparam logic [3:0]      PIX_MAX_C   = 4'(NUM_PIXELS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Picks one colour byte out of a GRB word; the reserved index reads 0.
    function automatic logic [7:0] color_byte(input logic [23:0] word,
                                              input logic [1:0]  sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[23:16];
            2'd1:    b = word[15:8];
            2'd2:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_e                          state_q, state_d;
    logic [HC_W-1:0]                 high_cnt_q, high_cnt_d;
    logic [LC_W-1:0]                 low_cnt_q, low_cnt_d;
    logic [4:0]                      bit_cnt_q, bit_cnt_d;
    logic [3:0]                      pix_cnt_q, pix_cnt_d;
    logic [22:0]                     shift_q, shift_d;
    logic [NUM_PIXELS-1:0]           written_q, written_d;
    logic [NUM_PIXELS-1:0][23:0]     shadow_q, shadow_d;
    logic [NUM_PIXELS-1:0][23:0]     active_q, active_d;
    logic [3:0]                      pixel_count_q, pixel_count_d;
    logic                            frame_valid_q, frame_valid_d;
    logic                            frame_error_q, frame_error_d;
    logic [7:0]                      rd_level_q, rd_level_d;

    logic                            bit_s;
    logic [23:0]                     word_s;
    logic                            word_done_s;
    logic [23:0]                     rd_word_s;

    // Line FSM: pulse measurement, bit assembly, shadow writes and latch commit.
    always_comb begin
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        shift_d       = shift_q;
        written_d     = written_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        pixel_count_d = pixel_count_q;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;
        bit_s         = (high_cnt_q >= THRESH_C);
        word_s        = {shift_q, bit_s};
        word_done_s   = (bit_cnt_q == 5'd23);

        case (state_q)
            ST_IDLE: begin
                if (bus.neo_data) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = HC_ONE;
                    bit_cnt_d  = 5'd0;
                    pix_cnt_d  = 4'd0;
                    written_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_HIGH: begin
                if (bus.neo_data) begin
                    if (high_cnt_q >= MAX_PRE_C) begin
                        // Stuck-high: the pulse reached the maximum legal width.
                        high_cnt_d = MAX_HIGH_C;
                        low_cnt_d  = '0;
                        state_d    = ST_ERR;
                    end else begin
                        high_cnt_d = high_cnt_q + HC_ONE;
                    end
                end else if (high_cnt_q < MIN_HIGH_C) begin
                    // Glitch: this low sample already counts toward recovery.
                    low_cnt_d = LC_ONE;
                    state_d   = ST_ERR;
                end else begin
                    shift_d   = word_s[22:0];
                    low_cnt_d = LC_ONE;
                    state_d   = ST_LOW;
                    if (word_done_s) begin
                        bit_cnt_d = 5'd0;
                        // Only the slot at pix_cnt takes the word; extra pixels
                        // past the last slot are dropped without error.
                        for (int i = 0; i < NUM_PIXELS; i++) begin
                            shadow_d[i]  = (pix_cnt_q == 4'(i)) ? word_s : shadow_q[i];
                            written_d[i] = (pix_cnt_q == 4'(i)) ? 1'b1 : written_q[i];
                        end
                        pix_cnt_d = (pix_cnt_q < PIX_MAX_C) ? (pix_cnt_q + 4'd1) : pix_cnt_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end

            ST_LOW: begin
                if (bus.neo_data) begin
                    high_cnt_d = HC_ONE;
                    state_d    = ST_HIGH;
                end else if (low_cnt_q >= LATCH_PRE_C) begin
                    low_cnt_d = LATCH_C;
                    state_d   = ST_IDLE;
                    if (bit_cnt_q == 5'd0) begin
                        // Whole pixels only: unwritten slots keep their old value.
                        for (int i = 0; i < NUM_PIXELS; i++) begin
                            active_d[i] = written_q[i] ? shadow_q[i] : active_q[i];
                        end
                        pixel_count_d = pix_cnt_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else begin
                    low_cnt_d = low_cnt_q + LC_ONE;
                end
            end

            ST_ERR: begin
                if (bus.neo_data) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q >= LATCH_PRE_C) begin
                    low_cnt_d     = LATCH_C;
                    frame_error_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + LC_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read mux: selects the addressed active word; out-of-range slots read 0.
    always_comb begin
        rd_word_s = 24'h000000;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            rd_word_s = rd_word_s | ({24{bus.rd_pixel_index == 3'(i)}} & active_q[i]);
        end
        rd_level_d = color_byte(rd_word_s, bus.rd_color_index);
    end

    // State and data registers with asynchronous clear of everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            bit_cnt_q     <= 5'd0;
            pix_cnt_q     <= 4'd0;
            shift_q       <= 23'd0;
            written_q     <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            pixel_count_q <= 4'd0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            rd_level_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            shift_q       <= shift_d;
            written_q     <= written_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pixel_count_q <= pixel_count_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            rd_level_q    <= rd_level_d;
        end
    end

    assign bus.rd_color_level = rd_level_q;
    assign bus.frame_valid    = frame_valid_q;
    assign bus.frame_error    = frame_error_q;
    assign bus.pixel_count    = pixel_count_q;

endmodule

// File: tb/tb_neopixel_decoder.sv
// Scoreboard bench for neopixel_decoder: stimulus tasks push expected frame
// events and read bytes into queues; a monitor pops and compares them when
// the decoder pulses or when a read result becomes due.
module tb_neopixel_decoder;

    localparam int T0H = 18;
    localparam int T0L = 44;
    localparam int T1H = 35;
    localparam int T1L = 27;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    neopixel_decoder_if bus();

    neopixel_decoder #(
        .NUM_PIXELS(5), .MIN_HIGH(5), .BIT_THRESH(27),
        .MAX_HIGH(60), .LATCH_CYCLES(2500)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic       is_valid;
        logic [3:0] pcount;
    } ev_t;

    int     tests_run    = 0;
    int     tests_failed = 0;
    ev_t    ev_q[$];
    logic [7:0] rd_exp_q[$];
    string  rd_name_q[$];
    bit     rd_issue = 1'b0;
    bit     rd_seen  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A read presented before this edge is due at the following negedge.
    always @(posedge clock) rd_seen <= rd_issue;

    // Monitor: compares read results and frame pulses against the queues.
    always @(negedge clock) begin
        if (rd_seen) begin
            if (rd_exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rd_underflow: read result 0x%0h with no expectation", bus.rd_color_level);
            end else begin
                check(rd_name_q.pop_front(), bus.rd_color_level, rd_exp_q.pop_front());
            end
        end
        if (bus.frame_valid || bus.frame_error) begin
            check("pulse_exclusive", bus.frame_valid & bus.frame_error, 0);
            if (ev_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_pulse: valid=%0b error=%0b, expected no pulse",
                         bus.frame_valid, bus.frame_error);
            end else begin
                ev_t e;
                e = ev_q.pop_front();
                check("pulse_kind_valid", bus.frame_valid, e.is_valid);
                if (e.is_valid) check("pixel_count", bus.pixel_count, e.pcount);
            end
        end
    end

    // All line tasks start and end on a negedge.
    task automatic line(input bit v, input int n);
        bus.neo_data = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_raw(input int hi, input int lo);
        line(1'b1, hi);
        line(1'b0, lo);
    endtask

    task automatic send_bit(input bit b, input int low_len);
        send_raw(b ? T1H : T0H, (low_len > 0) ? low_len : (b ? T1L : T0L));
    endtask

    task automatic send_word(input logic [23:0] w, input int last_low);
        for (int i = 23; i >= 0; i--) send_bit(w[i], (i == 0) ? last_low : 0);
    endtask

    task automatic latch(input bit valid, input logic [3:0] pc);
        ev_t e;
        e.is_valid = valid;
        e.pcount   = pc;
        ev_q.push_back(e);
        line(1'b0, 2600);
    endtask

    task automatic read_exp(input string name, input logic [2:0] p, input logic [1:0] c,
                            input logic [7:0] e);
        bus.rd_pixel_index = p;
        bus.rd_color_index = c;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(name);
        rd_issue = 1'b1;
        @(negedge clock);
        rd_issue = 1'b0;
    endtask

    logic [23:0] frame1 [5];

    initial begin
        frame1[0] = 24'hA53CFF;
        frame1[1] = 24'h010203;
        frame1[2] = 24'h102030;
        frame1[3] = 24'h445566;
        frame1[4] = 24'h807FC3;

        // Reset state
        bus.neo_data       = 1'b0;
        bus.rd_pixel_index = 3'd2;
        bus.rd_color_index = 2'd1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_level", bus.rd_color_level, 0);
        check("rst_valid", bus.frame_valid, 0);
        check("rst_error", bus.frame_error, 0);
        check("rst_pcount", bus.pixel_count, 0);
        reset = 1'b0;
        @(negedge clock);
        read_exp("rst_read_2_1", 3'd2, 2'd1, 8'h00);

        // Full frame
        for (int p = 0; p < 5; p++) send_word(frame1[p], 0);
        latch(1'b1, 4'd5);
        read_exp("full_0_0", 3'd0, 2'd0, 8'hA5);
        read_exp("full_0_1", 3'd0, 2'd1, 8'h3C);
        read_exp("full_0_2", 3'd0, 2'd2, 8'hFF);
        read_exp("full_7_0", 3'd7, 2'd0, 8'h00);
        read_exp("full_3_2", 3'd3, 2'd2, 8'h66);
        read_exp("full_4_1", 3'd4, 2'd1, 8'h7F);
        read_exp("full_1_3", 3'd1, 2'd3, 8'h00);

        // Partial pixel: 30 bits
        send_word(24'h123456, 0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 0);
        latch(1'b0, 4'd0);
        check("partial_pcount", bus.pixel_count, 5);
        read_exp("partial_0_0", 3'd0, 2'd0, 8'hA5);
        read_exp("partial_2_1", 3'd2, 2'd1, 8'h20);

        // Short frame: slots 2-4 keep old data
        send_word(24'h111111, 0);
        send_word(24'h111111, 0);
        latch(1'b1, 4'd2);
        check("short_pcount", bus.pixel_count, 2);
        read_exp("short_0_1", 3'd0, 2'd1, 8'h11);
        read_exp("short_1_2", 3'd1, 2'd2, 8'h11);
        read_exp("short_2_0", 3'd2, 2'd0, 8'h10);
        read_exp("short_4_2", 3'd4, 2'd2, 8'hC3);

        // Overflow frame: 6th pixel dropped
        for (int p = 0; p < 5; p++) send_word(24'h222222, 0);
        send_word(24'hEEEEEE, 0);
        latch(1'b1, 4'd5);
        read_exp("ovf_0_0", 3'd0, 2'd0, 8'h22);
        read_exp("ovf_4_2", 3'd4, 2'd2, 8'h22);
        read_exp("ovf_3_1", 3'd3, 2'd1, 8'h22);

        // Glitch high of 3 cycles mid-frame
        for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
        send_raw(3, 40);
        send_bit(1'b1, 0);
        latch(1'b0, 4'd0);
        read_exp("glitch_0_0", 3'd0, 2'd0, 8'h22);

        // Stuck high for 60 cycles
        for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
        line(1'b1, 60);
        latch(1'b0, 4'd0);
        read_exp("stuck_1_1", 3'd1, 2'd1, 8'h22);

        // Width boundaries: 27->1, 26->0, 5->0 (legal), 59->1
        send_raw(27, 40);
        send_raw(26, 40);
        send_raw(5, 40);
        send_raw(59, 40);
        for (int i = 0; i < 20; i++) send_bit(1'b0, 0);
        latch(1'b1, 4'd1);
        read_exp("width_0_0", 3'd0, 2'd0, 8'h90);
        read_exp("width_0_1", 3'd0, 2'd1, 8'h00);
        read_exp("width_1_0", 3'd1, 2'd0, 8'h22);

        // Reset mid-frame clears everything including the active buffer
        for (int i = 0; i < 12; i++) send_bit(1'b1, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("midrst_pcount", bus.pixel_count, 0);
        check("midrst_level", bus.rd_color_level, 0);
        reset = 1'b0;
        @(negedge clock);
        read_exp("midrst_1_0", 3'd1, 2'd0, 8'h00);
        send_word(24'h5AC30F, 0);
        latch(1'b1, 4'd1);
        read_exp("after_rst_0_1", 3'd0, 2'd1, 8'hC3);
        read_exp("after_rst_0_2", 3'd0, 2'd2, 8'h0F);
        read_exp("after_rst_1_0", 3'd1, 2'd0, 8'h00);

        // Near-latch: high after 2499 low cycles continues the frame
        send_word(24'h0000FF, 2499);
        send_word(24'h123456, 0);
        latch(1'b1, 4'd2);
        read_exp("near_0_2", 3'd0, 2'd2, 8'hFF);
        read_exp("near_1_0", 3'd1, 2'd0, 8'h12);
        read_exp("near_1_2", 3'd1, 2'd2, 8'h56);

        repeat (5) @(negedge clock);
        check("events_drained", ev_q.size(), 0);
        check("reads_drained", rd_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
